// File: rtl/wb2ahb_pkg.sv
// rtl/wb2ahb_pkg.sv - shared constants and FSM state type for the WB-to-AHB bridge
// Contents: HTRANS/HRESP/HSIZE/HBURST encodings, HPROT default, bridge state enum.
package wb2ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;
   localparam logic [1:0] HRESP_RETRY = 2'b10;
   localparam logic [1:0] HRESP_SPLIT = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   // Data access, privileged, non-bufferable, non-cacheable.
   localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ADDR,
      DATA,
      DONE
   } state_t;

endpackage

// File: rtl/wb2ahb_sel_decode.sv
// rtl/wb2ahb_sel_decode.sv - combinational WB byte-select to AHB size/offset decoder
// Ports: sel (WB lane select) in; valid, hsize, offset (index of lowest selected lane) out.
// Accepted: one byte, aligned halfword, aligned word, or all lanes when DWIDTH=64.
module wb2ahb_sel_decode
   import wb2ahb_pkg::*;
#(
   parameter int DWIDTH = 32,
   localparam int LW = DWIDTH / 8,
   localparam int OW = $clog2(LW)
) (
   input  logic [LW-1:0] sel,
   output logic          valid,
   output logic [2:0]    hsize,
   output logic [OW-1:0] offset
);

   always_comb begin
      valid  = 1'b0;
      hsize  = HSIZE_WORD;
      offset = '0;
      for (int i = 0; i < LW; i++) begin
         if (sel == (LW'(1) << i)) begin
            valid  = 1'b1;
            hsize  = HSIZE_BYTE;
            offset = OW'(i);
         end
      end
      for (int i = 0; i < LW; i += 2) begin
         if (sel == (LW'(2'b11) << i)) begin
            valid  = 1'b1;
            hsize  = HSIZE_HALF;
            offset = OW'(i);
         end
      end
      for (int i = 0; i < LW; i += 4) begin
         if (sel == (LW'(4'hf) << i)) begin
            valid  = 1'b1;
            hsize  = HSIZE_WORD;
            offset = OW'(i);
         end
      end
      if (LW == 8 && sel == '1) begin
         valid  = 1'b1;
         hsize  = HSIZE_DWORD;
         offset = '0;
      end
   end

endmodule

// File: rtl/wb2ahb_bridge.sv
// rtl/wb2ahb_bridge.sv - Wishbone classic slave to AHB master bridge, one SINGLE transfer per WB cycle
// Ports: clk_i, rst_i (async, active-high); WB slave adr_i/dat_i/dat_o/sel_i/we_i/cyc_i/stb_i/ack_o/err_o;
// AHB master haddr/htrans/hwrite/hsize/hburst/hprot/hwdata/hrdata/hready/hresp/hbusreq/hgrant.
// Option macro WBAHB_RETRY_EN: RETRY/SPLIT re-issue the transfer up to MAX_RETRY times;
// without it RETRY/SPLIT terminate like ERROR.
module wb2ahb_bridge
   import wb2ahb_pkg::*;
#(
   parameter int AWIDTH    = 32,
   parameter int DWIDTH    = 32,
   parameter int MAX_RETRY = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [AWIDTH-1:0]   adr_i,
   input  logic [DWIDTH-1:0]   dat_i,
   output logic [DWIDTH-1:0]   dat_o,
   input  logic [DWIDTH/8-1:0] sel_i,
   input  logic                we_i,
   input  logic                cyc_i,
   input  logic                stb_i,
   output logic                ack_o,
   output logic                err_o,
   output logic [AWIDTH-1:0]   haddr,
   output logic [1:0]          htrans,
   output logic                hwrite,
   output logic [2:0]          hsize,
   output logic [2:0]          hburst,
   output logic [3:0]          hprot,
   output logic [DWIDTH-1:0]   hwdata,
   input  logic [DWIDTH-1:0]   hrdata,
   input  logic                hready,
   input  logic [1:0]          hresp,
   output logic                hbusreq,
   input  logic                hgrant
);

   localparam int LW = DWIDTH / 8;
   localparam int OW = $clog2(LW);

   state_t            state;
   logic [AWIDTH-1:0] addr_q;
   logic [DWIDTH-1:0] dat_q;
   logic              we_q;
   logic [2:0]        size_q;
   logic              fail_q;

   logic              lane_valid;
   logic [2:0]        lane_size;
   logic [OW-1:0]     lane_off;

   wb2ahb_sel_decode #(.DWIDTH(DWIDTH)) u_sel_decode (
      .sel    (sel_i),
      .valid  (lane_valid),
      .hsize  (lane_size),
      .offset (lane_off)
   );

   // Low address bits are replaced by the lane offset, so they are never read.
`ifdef WBAHB_RETRY_EN
   localparam int RCW = $clog2(MAX_RETRY + 1);
   logic [RCW-1:0] retry_cnt;
   logic           unused_in;
   assign unused_in = ^adr_i[OW-1:0];
`else
   logic           unused_in;
   assign unused_in = ^{adr_i[OW-1:0], MAX_RETRY};
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         haddr   <= '0;
         htrans  <= HTRANS_IDLE;
         hwrite  <= 1'b0;
         hsize   <= HSIZE_WORD;
         hburst  <= HBURST_SINGLE;
         hprot   <= HPROT_DEFAULT;
         hwdata  <= '0;
         hbusreq <= 1'b0;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         dat_o   <= '0;
         addr_q  <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= HSIZE_WORD;
         fail_q  <= 1'b0;
`ifdef WBAHB_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               ack_o <= 1'b0;
               err_o <= 1'b0;
`ifdef WBAHB_RETRY_EN
               retry_cnt <= '0;
`endif
               // The ack_o/err_o guard stops a strobe held through termination
               // from starting a second access.
               if (cyc_i && stb_i && !ack_o && !err_o) begin
                  addr_q <= {adr_i[AWIDTH-1:OW], lane_off};
                  dat_q  <= dat_i;
                  we_q   <= we_i;
                  size_q <= lane_size;
                  fail_q <= !lane_valid;
                  if (lane_valid) begin
                     state   <= REQ;
                     hbusreq <= 1'b1;
                  end else begin
                     state <= DONE;
                  end
               end
            end

            REQ: begin
               if (hgrant && hready) begin
                  state  <= ADDR;
                  htrans <= HTRANS_NONSEQ;
                  haddr  <= addr_q;
                  hwrite <= we_q;
                  hsize  <= size_q;
               end
            end

            // Grant is not rechecked from here on: an issued transfer always completes.
            ADDR: begin
               if (hready) begin
                  state   <= DATA;
                  htrans  <= HTRANS_IDLE;
                  hbusreq <= 1'b0;
                  hwdata  <= dat_q;
               end
            end

            // hresp is only meaningful with hready high; the first cycle of a
            // two-cycle response is ignored.
            DATA: begin
               if (hready) begin
                  if (hresp == HRESP_OKAY) begin
                     if (!we_q) begin
                        dat_o <= hrdata;
                     end
                     state <= DONE;
`ifdef WBAHB_RETRY_EN
                  end else if (hresp == HRESP_RETRY || hresp == HRESP_SPLIT) begin
                     if (retry_cnt == RCW'(MAX_RETRY)) begin
                        fail_q <= 1'b1;
                        state  <= DONE;
                     end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= REQ;
                        hbusreq   <= 1'b1;
                     end
`endif
                  end else begin
                     fail_q <= 1'b1;
                     state  <= DONE;
                  end
               end
            end

            // Termination is suppressed if the master abandoned the cycle.
            DONE: begin
               ack_o <= cyc_i && !fail_q;
               err_o <= cyc_i && fail_q;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb2ahb_bridge.sv
// tb/tb_wb2ahb_bridge.sv - self-checking bench for wb2ahb_bridge
module tb_wb2ahb_bridge;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXR = 2;
`ifdef WBAHB_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [AW-1:0] adr_i;
   logic [DW-1:0] dat_i;
   logic [DW-1:0] dat_o;
   logic [3:0]    sel_i;
   logic          we_i, cyc_i, stb_i, ack_o, err_o;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize, hburst;
   logic [3:0]    hprot;
   logic [DW-1:0] hwdata, hrdata;
   logic          hready;
   logic [1:0]    hresp;
   logic          hbusreq, hgrant;

   wb2ahb_bridge #(.AWIDTH(AW), .DWIDTH(DW), .MAX_RETRY(MAXR)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
      .sel_i(sel_i), .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
      .err_o(err_o), .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready), .hresp(hresp), .hbusreq(hbusreq), .hgrant(hgrant)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One WB cycle against a reactive AHB slave. Expectations come from the
   // lane rules and a cycle-count formula, not from the DUT.
   task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit we, input logic [31:0] rdata,
                       input int gd, input int dw, input int nretry, input logic [1:0] fresp,
                       input bit drop, input bit hold);
      bit          valid, exp_err, bus_seen, term_seen;
      int          pc, lo, issues, lat, dcnt, reqcnt, nonseq, done_at, stop_at;
      logic [1:0]  resp_k;
      logic [31:0] cap_addr, cap_wdata, cap_rdata;
      logic [2:0]  cap_size;
      logic        cap_write, cap_ack, cap_err;
      pc = 0; lo = 0;
      cap_addr = '0; cap_wdata = '0; cap_rdata = '0; cap_size = '0;
      cap_write = 1'b0; cap_ack = 1'b0; cap_err = 1'b0;
      for (int i = 3; i >= 0; i--) if (sel[i]) begin pc++; lo = i; end
      valid = (pc inside {1, 2, 4}) ? ((lo % pc == 0) && (sel == 4'(((1 << pc) - 1) << lo))) : 1'b0;
      if (!valid) begin
         issues = 0; exp_err = 1'b1; lat = 1;
      end else begin
         if (nretry == 0) begin issues = 1; exp_err = (fresp != 2'b00); end
         else if (!RETRY_EN) begin issues = 1; exp_err = 1'b1; end
         else if (nretry > MAXR) begin issues = MAXR + 1; exp_err = 1'b1; end
         else begin issues = nretry + 1; exp_err = (fresp != 2'b00); end
         lat = 1 + gd + issues * (3 + dw);
      end

      @(negedge clk_i);
      adr_i = adr; dat_i = dat; sel_i = sel; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
      hgrant = (gd == 0); hready = 1'b1; hresp = 2'b00; hrdata = $urandom;
      dcnt = -1; reqcnt = 0; nonseq = 0; done_at = -1; bus_seen = 1'b0; term_seen = 1'b0;
      stop_at = drop ? lat + 2 : 80;
      for (int n = 0; n <= stop_at; n++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (drop && n == 0) begin cyc_i = 1'b0; stb_i = 1'b0; end
         if (hbusreq) bus_seen = 1'b1;
         if (hbusreq && htrans == 2'b00) begin
            reqcnt++;
            if (reqcnt > gd) hgrant = 1'b1;
         end
         if (htrans == 2'b10) begin
            nonseq++;
            if (nonseq == 1) begin cap_addr = haddr; cap_size = hsize; cap_write = hwrite; end
            dcnt = 0; hready = 1'b1; hresp = 2'b00;
         end else if (dcnt >= 0) begin
            if (dcnt == 0 && nonseq == 1) cap_wdata = hwdata;
            resp_k = (nonseq <= nretry) ? 2'b10 : fresp;
            if (dcnt < dw) begin
               hready = 1'b0;
               hresp  = (resp_k != 2'b00 && dcnt == dw - 1) ? resp_k : 2'b00;
               hrdata = $urandom;
               dcnt++;
            end else begin
               hready = 1'b1; hresp = resp_k; hrdata = rdata; dcnt = -1;
            end
         end else begin
            hready = 1'b1; hresp = 2'b00;
         end
         if (done_at < 0 && (ack_o || err_o)) begin
            done_at = n; cap_ack = ack_o; cap_err = err_o; cap_rdata = dat_o; term_seen = 1'b1;
            if (!hold) begin cyc_i = 1'b0; stb_i = 1'b0; end
            if (!drop) stop_at = n + (hold ? 2 : 1);
         end else if (done_at >= 0 && n == done_at + 1) begin
            check({tag, ".pulse"}, {ack_o, err_o}, 2'b00);
            if (hold) begin
               check({tag, ".no_restart"}, hbusreq, 1'b0);
               cyc_i = 1'b0; stb_i = 1'b0;
            end
         end
      end
      cyc_i = 1'b0; stb_i = 1'b0; hgrant = 1'b1; hready = 1'b1; hresp = 2'b00;

      if (drop) check({tag, ".suppressed"}, term_seen, 1'b0);
      else begin
         check({tag, ".latency"}, done_at, lat);
         check({tag, ".ack"}, cap_ack, !exp_err);
         check({tag, ".err"}, cap_err, exp_err);
      end
      check({tag, ".issues"}, nonseq, issues);
      check({tag, ".busreq"}, bus_seen, valid);
      if (valid && nonseq > 0) begin
         check({tag, ".haddr"}, cap_addr, (adr & ~32'd3) | lo);
         check({tag, ".hsize"}, cap_size, $clog2(pc));
         check({tag, ".hwrite"}, cap_write, we);
         if (we) check({tag, ".hwdata"}, cap_wdata, dat);
      end
      if (!drop && valid && !we && !exp_err && done_at >= 0)
         check({tag, ".dat_o"}, cap_rdata, rdata);
   endtask

   initial begin
      logic [3:0] rsel;
      int         rdw, rnr, quiet;
      logic [1:0] rresp;

      rst_i = 1'b1; adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0;
      cyc_i = 1'b0; stb_i = 1'b0; hrdata = '0; hready = 1'b1; hresp = 2'b00; hgrant = 1'b1;
      repeat (2) @(negedge clk_i);
      check("reset.haddr", haddr, 32'h0);
      check("reset.htrans", htrans, 2'b00);
      check("reset.hwrite", hwrite, 1'b0);
      check("reset.hsize", hsize, 3'b010);
      check("reset.hburst", hburst, 3'b000);
      check("reset.hprot", hprot, 4'b0011);
      check("reset.hwdata", hwdata, 32'h0);
      check("reset.hbusreq", hbusreq, 1'b0);
      check("reset.ack_err", {ack_o, err_o}, 2'b00);
      check("reset.dat_o", dat_o, 32'h0);
      rst_i = 1'b0;

      //   tag        adr           dat           sel    we rdata         gd dw nr fresp drop hold
      xfer("wr_word",  32'h1000, 32'hDEADBEEF, 4'b1111, 1, 32'h0,        0, 0, 0, 2'b00, 0, 0);
      xfer("rd_byte2", 32'h2000, 32'h0,        4'b0100, 0, 32'h00AB0000, 0, 2, 0, 2'b00, 0, 0);
      xfer("error",    32'h2004, 32'h0,        4'b1111, 0, 32'h0,        0, 1, 0, 2'b01, 0, 0);
      xfer("bad_sel",  32'h3000, 32'h0,        4'b0110, 1, 32'h0,        0, 0, 0, 2'b00, 0, 0);
      xfer("zero_sel", 32'h3004, 32'h0,        4'b0000, 0, 32'h0,        0, 0, 0, 2'b00, 0, 0);
      xfer("retry2",   32'h4000, 32'h12345678, 4'b0011, 1, 32'h0,        0, 1, 2, 2'b00, 0, 0);
      xfer("retry3",   32'h4010, 32'h0,        4'b1100, 0, 32'h55AA0000, 0, 1, 3, 2'b00, 0, 0);
      xfer("gnt_hold", 32'h5008, 32'hCAFEF00D, 4'b1000, 1, 32'h0,        3, 0, 0, 2'b00, 0, 1);
      xfer("cyc_drop", 32'h600C, 32'h0,        4'b1111, 0, 32'h01020304, 0, 1, 0, 2'b00, 1, 0);

      // Grant withheld for five REQ cycles, then an asynchronous reset.
      @(negedge clk_i);
      adr_i = 32'h7000; dat_i = 32'h0BADCAFE; sel_i = 4'hf; we_i = 1'b1;
      cyc_i = 1'b1; stb_i = 1'b1; hgrant = 1'b0;
      repeat (6) @(negedge clk_i);
      check("rst_mid.req_busreq", hbusreq, 1'b1);
      check("rst_mid.req_htrans", htrans, 2'b00);
      #2 rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0;
      #1;
      check("rst_mid.busreq", hbusreq, 1'b0);
      check("rst_mid.htrans", htrans, 2'b00);
      @(negedge clk_i);
      rst_i = 1'b0; hgrant = 1'b1;
      quiet = 0;
      repeat (4) begin
         @(negedge clk_i);
         if (ack_o || err_o || hbusreq) quiet++;
      end
      check("rst_mid.quiet", quiet, 0);

      for (int k = 0; k < 25; k++) begin
         rsel  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
               : 4'(8'h1 << $urandom_range(0, 3)) | (($urandom_range(0, 1) == 1) ? 4'hf : 4'h0);
         rdw   = $urandom_range(0, 2);
         rresp = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
         rnr   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         if ((rresp != 2'b00 || rnr > 0) && rdw == 0) rdw = 1;
         xfer($sformatf("rnd%0d", k), $urandom, $urandom, rsel, 1'($urandom_range(0, 1)),
              $urandom, $urandom_range(0, 2), rdw, rnr, rresp, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb2ahb_bridge.md
# wb2ahb_bridge

Parametrised, single-clock Wishbone-slave to AHB-master bridge, the next generation of our WB→AHB bridge. It accepts one classic Wishbone cycle at a time from a WB master and executes it as one AHB SINGLE transfer. A registered state machine runs the transfer through bus request/grant, a pipelined address/data phase and the two-cycle AHB responses. It returns the result as a one-cycle ack_o or err_o and supports byte/halfword/word/doubleword lanes via sel_i.

## Interface
Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, data width; 32 or 64 only.
- MAX_RETRY, 4, re-issue limit for RETRY/SPLIT responses (used only with WBAHB_RETRY_EN).

Ports:
- clk_i  in  1  single clock for both bus sides.
- rst_i  in  1  reset, asynchronous, active-high.
- adr_i  in  AWIDTH  WB address.
- dat_i  in  DWIDTH  WB write data.
- dat_o  out  DWIDTH  WB read data.
- sel_i  in  DWIDTH/8  WB byte lane select.
- we_i  in  1  WB write enable.
- cyc_i, stb_i  in  1 each  WB cycle and strobe.
- ack_o, err_o  out  1 each  WB termination pulses.
- haddr  out  AWIDTH  AHB address.
- htrans  out  2  AHB transfer type.
- hwrite  out  1  AHB write/read control.
- hsize  out  3  AHB transfer size.
- hburst  out  3  AHB burst type.
- hprot  out  4  AHB protection.
- hwdata  out  DWIDTH  AHB write data.
- hrdata  in  DWIDTH  AHB read data.
- hready  in  1  AHB ready.
- hresp  in  2  AHB response.
- hbusreq  out  1  AHB bus request.
- hgrant  in  1  AHB grant.

## Operation
- All outputs are registered.
- Reset values:
  - haddr=0, htrans=IDLE(00), hwrite=0, hsize=010, hburst=SINGLE(000), hprot=0011.
  - hwdata=0, hbusreq=0, ack_o=0, err_o=0, dat_o=0.
- State IDLE:
  - On cyc_i&stb_i&!ack_o&!err_o, latch adr_i, dat_i, sel_i and we_i.
  - If sel_i is invalid, go to DONE with error and perform no AHB access.
  - Otherwise go to REQ.
- State REQ:
  - hbusreq=1.
  - On hgrant&hready, go to ADDR.
- State ADDR:
  - htrans=NONSEQ; haddr, hwrite and hsize are valid; hbusreq stays 1.
  - On hready, go to DATA.
- State DATA:
  - htrans=IDLE, hbusreq=0, hwdata=latched data.
  - On hready&hresp==OKAY, go to DONE; for a read, dat_o<=hrdata.
  - On hready&hresp==ERROR, go to DONE with error.
  - The first, hready=0 cycle of a two-cycle response causes no action.
- State DONE:
  - Exactly one of ack_o or err_o is high for one cycle, then the FSM returns to IDLE.
- Lane decode (sel_i → hsize and haddr low bits, little-endian):
  - The accepted patterns are a single byte, an aligned halfword (0011/1100 pairs), an aligned word, or all ones for a doubleword (DWIDTH=64 only).
  - The low bits of haddr are the index of the lowest set lane; the upper bits come from adr_i.
  - Every other pattern, including 0, is invalid.
- Boundary conditions:
  - cyc_i dropped after IDLE: the AHB transfer still completes (it cannot be aborted), ack_o and err_o are suppressed, and the FSM returns to IDLE.
  - hgrant removed while in REQ: the FSM stays in REQ.
  - hgrant removed in ADDR or DATA: the current transfer finishes, as AHB requires.
  - rst_i asserted mid-transfer: the FSM returns to IDLE immediately and all outputs take their reset values without waiting for a clock.
  - stb_i held high through ack_o: no second access starts; a new cycle requires the master to present stb_i again after the termination cycle.

## Timing
- Zero-wait-state case (hgrant already high, hready=1): stb_i sampled at edge 0 gives REQ@1, ADDR@2, DATA@3, DONE@4, so ack_o is high in the cycle after edge 4.
- Each hready=0 cycle in ADDR or DATA adds one cycle.
- An invalid sel_i gives err_o after edge 1.
- hresp is only sampled when hready=1 in DATA.

## Configuration
- WBAHB_RETRY_EN defined:
  - A RETRY or SPLIT response increments a retry counter and sends the FSM back to REQ, re-issuing the identical transfer.
  - When the count reaches MAX_RETRY, the transfer ends with err_o.
  - The counter is cleared in IDLE.
- WBAHB_RETRY_EN undefined:
  - RETRY and SPLIT are treated exactly as ERROR.
  - No counter logic is present.

## Structure
- Package wb2ahb_pkg holds:
  - The HTRANS, HRESP, HSIZE and HBURST constants.
  - The FSM state enum {IDLE, REQ, ADDR, DATA, DONE}.
  - The HPROT default.
- Sub-module wb2ahb_sel_decode is purely combinational: sel_i in, {valid, hsize, lane offset} out.

## Test plan
- Write, DWIDTH=32, adr_i=0x1000, sel_i=1111, dat_i=0xDEADBEEF, hgrant=1, hready=1 → haddr=0x1000, hsize=010, hwdata=0xDEADBEEF in DATA, ack_o 4 cycles after stb_i.
- Read, sel_i=0100, adr_i=0x2000, hrdata=0x00AB0000 with 2 wait states in DATA → haddr=0x2002, hsize=000, dat_o=0x00AB0000, ack_o after 6 cycles.
- ERROR (hready=0/hresp=01, then hready=1/hresp=01) → err_o one cycle, ack_o stays 0.
- sel_i=0110 → err_o after edge 1, htrans never NONSEQ, hbusreq never 1.
- With WBAHB_RETRY_EN and MAX_RETRY=2: two RETRYs then OKAY → 3 NONSEQ issues then ack_o; three RETRYs → err_o after the third.
- hgrant held low 5 cycles in REQ, then rst_i pulsed → hbusreq=0 and htrans=IDLE immediately, with no ack_o.
